// File: rtl/lsq_buffer.sv
// In-order load/store queue between dispatch and the LSU: captures memory ops,
// wakes operands from the result buses, and issues strictly from the head.
module lsq_buffer #(
    parameter int DEPTH       = 8,
    parameter int ROB_W       = 4,
    parameter int XLEN        = 32,
    parameter int NUM_CDB     = 2,
    parameter int FULL_MARGIN = 2,
    parameter logic [XLEN-1:0] IO_ADDR = 32'h30000
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rdy,
    input  logic                     disp_valid,
    input  logic [3:0]               disp_op,
    input  logic [XLEN-1:0]          disp_v1,
    input  logic [XLEN-1:0]          disp_v2,
    input  logic [XLEN-1:0]          disp_imm,
    input  logic [ROB_W-1:0]         disp_q1,
    input  logic [ROB_W-1:0]         disp_q2,
    input  logic [ROB_W-1:0]         disp_rob,
    input  logic [NUM_CDB-1:0]       cdb_valid,
    input  logic [NUM_CDB*ROB_W-1:0] cdb_rob,
    input  logic [NUM_CDB*XLEN-1:0]  cdb_data,
    input  logic                     lsu_busy,
    output logic                     lsu_req,
    output logic [3:0]               lsu_op,
    output logic [XLEN-1:0]          lsu_addr,
    output logic [XLEN-1:0]          lsu_wdata,
    output logic [ROB_W-1:0]         lsu_rob,
    input  logic                     commit_valid,
    input  logic [ROB_W-1:0]         commit_rob,
    input  logic [ROB_W-1:0]         io_rob_in,
    output logic [ROB_W-1:0]         io_rob_out,
    input  logic                     flush,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] cmt_q, cmt_d;
    logic [3:0]       op_q [DEPTH];
    logic [3:0]       op_d [DEPTH];
    logic [XLEN-1:0]  v1_q [DEPTH];
    logic [XLEN-1:0]  v1_d [DEPTH];
    logic [XLEN-1:0]  v2_q [DEPTH];
    logic [XLEN-1:0]  v2_d [DEPTH];
    logic [XLEN-1:0]  imm_q [DEPTH];
    logic [XLEN-1:0]  imm_d [DEPTH];
    logic [ROB_W-1:0] q1_q [DEPTH];
    logic [ROB_W-1:0] q1_d [DEPTH];
    logic [ROB_W-1:0] q2_q [DEPTH];
    logic [ROB_W-1:0] q2_d [DEPTH];
    logic [ROB_W-1:0] rob_q [DEPTH];
    logic [ROB_W-1:0] rob_d [DEPTH];

    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d, ccnt_q, ccnt_d;

    logic             lsu_req_q, lsu_req_d;
    logic [3:0]       lsu_op_q, lsu_op_d;
    logic [XLEN-1:0]  lsu_addr_q, lsu_addr_d;
    logic [XLEN-1:0]  lsu_wdata_q, lsu_wdata_d;
    logic [ROB_W-1:0] lsu_rob_q, lsu_rob_d;

    logic [XLEN-1:0]  headAddr;
    logic             headStore;
    logic             issue;
    logic             doDisp;
    logic             commitHit;
    logic [XLEN:0]    disp1Hit, disp2Hit, wake1, wake2;

    // Returns {hit, data}; scanning from the top channel down lets the lowest index win.
    function automatic logic [XLEN:0] cdbLookup(
        input logic [ROB_W-1:0]         tag,
        input logic [NUM_CDB-1:0]       vld,
        input logic [NUM_CDB*ROB_W-1:0] robs,
        input logic [NUM_CDB*XLEN-1:0]  data
    );
        cdbLookup = '0;
        for (int k = NUM_CDB - 1; k >= 0; k--) begin
            if (vld[k] && tag != '0 && robs[k*ROB_W +: ROB_W] == tag)
                cdbLookup = {1'b1, data[k*XLEN +: XLEN]};
        end
    endfunction

    assign headAddr  = v1_q[head_q] + imm_q[head_q];
    assign headStore = op_q[head_q] >= 4'd5;

    assign issue = !flush && valid_q[head_q] && q1_q[head_q] == '0 && q2_q[head_q] == '0
                 && !lsu_busy && !lsu_req_q
                 && (headStore ? cmt_q[head_q]
                               : (headAddr != IO_ADDR || io_rob_in == rob_q[head_q]));

    assign doDisp = disp_valid && !flush && count_q != CW'(DEPTH);

    always_comb begin
        valid_d     = valid_q;
        cmt_d       = cmt_q;
        op_d        = op_q;
        v1_d        = v1_q;
        v2_d        = v2_q;
        imm_d       = imm_q;
        q1_d        = q1_q;
        q2_d        = q2_q;
        rob_d       = rob_q;
        head_d      = head_q;
        tail_d      = tail_q;
        lsu_req_d   = issue;
        lsu_op_d    = lsu_op_q;
        lsu_addr_d  = lsu_addr_q;
        lsu_wdata_d = lsu_wdata_q;
        lsu_rob_d   = lsu_rob_q;
        commitHit   = 1'b0;
        wake1       = '0;
        wake2       = '0;
        disp1Hit    = cdbLookup(disp_q1, cdb_valid, cdb_rob, cdb_data);
        disp2Hit    = cdbLookup(disp_q2, cdb_valid, cdb_rob, cdb_data);

        for (int i = 0; i < DEPTH; i++) begin
            if (!flush && valid_q[i]) begin
                wake1 = cdbLookup(q1_q[i], cdb_valid, cdb_rob, cdb_data);
                wake2 = cdbLookup(q2_q[i], cdb_valid, cdb_rob, cdb_data);
                if (wake1[XLEN]) begin
                    q1_d[i] = '0;
                    v1_d[i] = wake1[XLEN-1:0];
                end
                if (wake2[XLEN]) begin
                    q2_d[i] = '0;
                    v2_d[i] = wake2[XLEN-1:0];
                end
            end
            if (commit_valid && valid_q[i] && op_q[i] >= 4'd5 && !cmt_q[i]
                && rob_q[i] == commit_rob) begin
                cmt_d[i]  = 1'b1;
                commitHit = 1'b1;
            end
        end

        if (issue) begin
            valid_d[head_q] = 1'b0;
            cmt_d[head_q]   = 1'b0;
            head_d          = head_q + PTR_W'(1);
            lsu_op_d        = op_q[head_q];
            lsu_addr_d      = headAddr;
            lsu_wdata_d     = v2_q[head_q];
            lsu_rob_d       = rob_q[head_q];
        end

        if (doDisp) begin
            valid_d[tail_q] = 1'b1;
            cmt_d[tail_q]   = 1'b0;
            op_d[tail_q]    = disp_op;
            imm_d[tail_q]   = disp_imm;
            rob_d[tail_q]   = disp_rob;
            q1_d[tail_q]    = disp1Hit[XLEN] ? '0 : disp_q1;
            v1_d[tail_q]    = disp1Hit[XLEN] ? disp1Hit[XLEN-1:0] : disp_v1;
            q2_d[tail_q]    = disp2Hit[XLEN] ? '0 : disp_q2;
            v2_d[tail_q]    = disp2Hit[XLEN] ? disp2Hit[XLEN-1:0] : disp_v2;
            tail_d          = tail_q + PTR_W'(1);
        end

        ccnt_d  = ccnt_q + CW'(commitHit) - CW'(issue && headStore);
        count_d = count_q + CW'(doDisp) - CW'(issue);

        // Committed stores sit contiguously at the head, so the survivors end at head+ccnt.
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (!cmt_d[i])
                    valid_d[i] = 1'b0;
            end
            tail_d  = head_q + ccnt_d[PTR_W-1:0];
            count_d = ccnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q     <= '0;
            cmt_q       <= '0;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            ccnt_q      <= '0;
            lsu_req_q   <= 1'b0;
            lsu_op_q    <= '0;
            lsu_addr_q  <= '0;
            lsu_wdata_q <= '0;
            lsu_rob_q   <= '0;
        end else if (rdy) begin
            valid_q     <= valid_d;
            cmt_q       <= cmt_d;
            op_q        <= op_d;
            v1_q        <= v1_d;
            v2_q        <= v2_d;
            imm_q       <= imm_d;
            q1_q        <= q1_d;
            q2_q        <= q2_d;
            rob_q       <= rob_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            ccnt_q      <= ccnt_d;
            lsu_req_q   <= lsu_req_d;
            lsu_op_q    <= lsu_op_d;
            lsu_addr_q  <= lsu_addr_d;
            lsu_wdata_q <= lsu_wdata_d;
            lsu_rob_q   <= lsu_rob_d;
        end
    end

    assign lsu_req    = lsu_req_q;
    assign lsu_op     = lsu_op_q;
    assign lsu_addr   = lsu_addr_q;
    assign lsu_wdata  = lsu_wdata_q;
    assign lsu_rob    = lsu_rob_q;
    assign count      = count_q;
    assign full       = count_q >= CW'(DEPTH - FULL_MARGIN);
    assign io_rob_out = (valid_q[head_q] && !headStore && headAddr == IO_ADDR)
                      ? rob_q[head_q] : '0;

endmodule

// File: tb/tb_lsq_buffer.sv
// Directed bench for lsq_buffer: issue timing, CDB wakeup, commit gating, IO loads,
// flush recovery, full/overflow, wrap-around drain and the rdy hold.
module tb_lsq_buffer;

    localparam int ROB_W = 4;
    localparam int XLEN  = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             rdy;
    logic             disp_valid;
    logic [3:0]       disp_op;
    logic [XLEN-1:0]  disp_v1, disp_v2, disp_imm;
    logic [ROB_W-1:0] disp_q1, disp_q2, disp_rob;
    logic [1:0]       cdb_valid;
    logic [2*ROB_W-1:0] cdb_rob;
    logic [2*XLEN-1:0]  cdb_data;
    logic             lsu_busy;
    logic             lsu_req;
    logic [3:0]       lsu_op;
    logic [XLEN-1:0]  lsu_addr, lsu_wdata;
    logic [ROB_W-1:0] lsu_rob;
    logic             commit_valid;
    logic [ROB_W-1:0] commit_rob;
    logic [ROB_W-1:0] io_rob_in;
    logic [ROB_W-1:0] io_rob_out;
    logic             flush;
    logic             full;
    logic [3:0]       count;

    int compared   = 0;
    int mismatched = 0;

    lsq_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .disp_valid(disp_valid), .disp_op(disp_op), .disp_v1(disp_v1),
        .disp_v2(disp_v2), .disp_imm(disp_imm), .disp_q1(disp_q1),
        .disp_q2(disp_q2), .disp_rob(disp_rob),
        .cdb_valid(cdb_valid), .cdb_rob(cdb_rob), .cdb_data(cdb_data),
        .lsu_busy(lsu_busy), .lsu_req(lsu_req), .lsu_op(lsu_op),
        .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata), .lsu_rob(lsu_rob),
        .commit_valid(commit_valid), .commit_rob(commit_rob),
        .io_rob_in(io_rob_in), .io_rob_out(io_rob_out),
        .flush(flush), .full(full), .count(count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs set before tick() are seen at the next rising edge; outputs are read 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [XLEN-1:0] v1,
                                 input logic [XLEN-1:0] v2, input logic [XLEN-1:0] imm,
                                 input logic [ROB_W-1:0] q1, input logic [ROB_W-1:0] q2,
                                 input logic [ROB_W-1:0] rob);
        disp_valid = 1'b1;
        disp_op    = op;
        disp_v1    = v1;
        disp_v2    = v2;
        disp_imm   = imm;
        disp_q1    = q1;
        disp_q2    = q2;
        disp_rob   = rob;
        tick();
        disp_valid = 1'b0;
        disp_q1    = '0;
        disp_q2    = '0;
    endtask

    task automatic commitRob(input logic [ROB_W-1:0] rob);
        commit_valid = 1'b1;
        commit_rob   = rob;
        tick();
        commit_valid = 1'b0;
    endtask

    initial begin
        bit seen;
        rst = 1'b1; rdy = 1'b1; disp_valid = 1'b0; disp_op = '0;
        disp_v1 = '0; disp_v2 = '0; disp_imm = '0;
        disp_q1 = '0; disp_q2 = '0; disp_rob = '0;
        cdb_valid = '0; cdb_rob = '0; cdb_data = '0;
        lsu_busy = 1'b0; commit_valid = 1'b0; commit_rob = '0;
        io_rob_in = '0; flush = 1'b0;
        tick(); tick();
        rst = 1'b0;
        checkOutput("rst_count", count, 0);
        checkOutput("rst_full", full, 0);
        checkOutput("rst_req", lsu_req, 0);
        checkOutput("rst_addr", lsu_addr, 0);
        checkOutput("rst_io", io_rob_out, 0);

        // Ready load: issues one edge after dispatch
        applyStimulus(4'd2, 32'h100, 32'h0, 32'h4, 4'd0, 4'd0, 4'd3);
        checkOutput("ld_cnt1", count, 1);
        checkOutput("ld_noreq", lsu_req, 0);
        tick();
        checkOutput("ld_req", lsu_req, 1);
        checkOutput("ld_addr", lsu_addr, 32'h104);
        checkOutput("ld_rob", lsu_rob, 3);
        checkOutput("ld_op", lsu_op, 2);
        checkOutput("ld_cnt0", count, 0);
        tick();
        checkOutput("ld_pulse", lsu_req, 0);
        checkOutput("ld_hold", lsu_addr, 32'h104);

        // Store waits on CDB channel 1, then on commit
        applyStimulus(4'd7, 32'h200, 32'h0, 32'h0, 4'd0, 4'd5, 4'd4);
        cdb_valid = 2'b10; cdb_rob = {4'd5, 4'd0}; cdb_data = {32'hDEADBEEF, 32'h0};
        tick();
        cdb_valid = '0;
        tick(); tick();
        checkOutput("st_nocommit", lsu_req, 0);
        checkOutput("st_cnt", count, 1);
        commitRob(4'd4);
        checkOutput("st_commit_edge", lsu_req, 0);
        tick();
        checkOutput("st_req", lsu_req, 1);
        checkOutput("st_wdata", lsu_wdata, 32'hDEADBEEF);
        checkOutput("st_addr", lsu_addr, 32'h200);
        checkOutput("st_op", lsu_op, 7);
        tick();

        // IO load blocks the head until the ROB marks it non-speculative
        applyStimulus(4'd2, 32'h30000, 32'h0, 32'h0, 4'd0, 4'd0, 4'd7);
        checkOutput("io_out", io_rob_out, 7);
        applyStimulus(4'd2, 32'h40, 32'h0, 32'h0, 4'd0, 4'd0, 4'd8);
        tick(); tick();
        checkOutput("io_held", lsu_req, 0);
        checkOutput("io_cnt", count, 2);
        io_rob_in = 4'd7;
        tick();
        io_rob_in = 4'd0;
        checkOutput("io_req", lsu_req, 1);
        checkOutput("io_rob", lsu_rob, 7);
        checkOutput("io_addr", lsu_addr, 32'h30000);
        checkOutput("io_out_clear", io_rob_out, 0);
        tick();
        checkOutput("io_no_b2b", lsu_req, 0);
        tick();
        checkOutput("io_young_req", lsu_req, 1);
        checkOutput("io_young_rob", lsu_rob, 8);
        tick();

        // Flush keeps committed stores, including one committed in the flush cycle
        lsu_busy = 1'b1;
        applyStimulus(4'd5, 32'h500, 32'h11, 32'h0, 4'd0, 4'd0, 4'd1);
        applyStimulus(4'd6, 32'h504, 32'h22, 32'h0, 4'd0, 4'd0, 4'd2);
        commitRob(4'd1);
        applyStimulus(4'd2, 32'h600, 32'h0, 32'h0, 4'd0, 4'd0, 4'd3);
        applyStimulus(4'd7, 32'h604, 32'h33, 32'h0, 4'd0, 4'd0, 4'd4);
        applyStimulus(4'd0, 32'h608, 32'h0, 32'h0, 4'd0, 4'd0, 4'd5);
        checkOutput("fl_pre_cnt", count, 5);
        checkOutput("fl_pre_full", full, 0);
        flush = 1'b1; commit_valid = 1'b1; commit_rob = 4'd2;
        tick();
        flush = 1'b0; commit_valid = 1'b0;
        checkOutput("fl_cnt", count, 2);
        checkOutput("fl_tail", dut.tail_q, 6);
        lsu_busy = 1'b0;
        tick();
        checkOutput("fl_st1_req", lsu_req, 1);
        checkOutput("fl_st1_rob", lsu_rob, 1);
        checkOutput("fl_st1_wd", lsu_wdata, 32'h11);
        tick(); tick();
        checkOutput("fl_st2_req", lsu_req, 1);
        checkOutput("fl_st2_rob", lsu_rob, 2);
        checkOutput("fl_st2_op", lsu_op, 6);
        tick(); tick(); tick(); tick();
        checkOutput("fl_quiet", lsu_req, 0);
        checkOutput("fl_last_rob", lsu_rob, 2);
        checkOutput("fl_cnt0", count, 0);

        // Fill past the margin, overflow once, then drain across the wrap point
        lsu_busy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'd2, 32'h1000 + 32'(i * 4), 32'h0, 32'h0, 4'd0, 4'd0, 4'(i + 1));
            if (i == 4) checkOutput("fill_not_full", full, 0);
            if (i == 5) checkOutput("fill_full", full, 1);
        end
        checkOutput("fill_cnt8", count, 8);
        applyStimulus(4'd2, 32'h9999, 32'h0, 32'h0, 4'd0, 4'd0, 4'd9);
        checkOutput("ovf_cnt", count, 8);
        lsu_busy = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen = 1'b0;
            for (int c = 0; c < 4 && !seen; c++) begin
                tick();
                if (lsu_req) seen = 1'b1;
            end
            checkOutput($sformatf("drain_req%0d", i), seen, 1);
            checkOutput($sformatf("drain_addr%0d", i), lsu_addr, 32'h1000 + 32'(i * 4));
        end
        tick(); tick(); tick();
        checkOutput("drain_quiet", lsu_req, 0);
        checkOutput("drain_cnt0", count, 0);
        checkOutput("drain_full0", full, 0);

        // Same-cycle CDB capture at dispatch, both channels hit, channel 0 wins
        cdb_valid = 2'b11; cdb_rob = {4'd9, 4'd9}; cdb_data = {32'h30, 32'h20};
        applyStimulus(4'd2, 32'h0, 32'h0, 32'h0, 4'd9, 4'd0, 4'd10);
        cdb_valid = '0;
        tick();
        checkOutput("cdb_disp_req", lsu_req, 1);
        checkOutput("cdb_disp_addr", lsu_addr, 32'h20);
        checkOutput("cdb_disp_rob", lsu_rob, 10);
        tick();

        // rdy low freezes everything, including a pending pulse
        lsu_busy = 1'b1;
        applyStimulus(4'd2, 32'h700, 32'h0, 32'h0, 4'd0, 4'd0, 4'd11);
        rdy = 1'b0; lsu_busy = 1'b0;
        tick(); tick(); tick();
        checkOutput("rdy_hold_req", lsu_req, 0);
        checkOutput("rdy_hold_cnt", count, 1);
        rdy = 1'b1;
        tick();
        checkOutput("rdy_req", lsu_req, 1);
        checkOutput("rdy_addr", lsu_addr, 32'h700);
        rdy = 1'b0;
        tick(); tick();
        checkOutput("rdy_pulse_hold", lsu_req, 1);
        rdy = 1'b1;
        tick();
        checkOutput("rdy_pulse_end", lsu_req, 0);
        checkOutput("rdy_cnt0", count, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
